// File: rtl/minimig_zorro_decode.sv
// Zorro II board decoder for the autoconfig window, Toccata and control board, with wait states.
// Optional WAIT-state bus-error timeout is built when ZORRO_TIMEOUT_EN is defined.
module minimig_zorro_decode #(
  parameter int WAIT_TOCCATA  = 2,
  parameter int WAIT_CONTROL  = 1,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [23:1] cpu_addr,
  input  logic        cpu_as,
  input  logic        autoconfig_done,
  input  logic [5:0]  board_configured,
  input  logic [5:0]  board_shutup,
  input  logic [7:0]  toccata_base_addr,
  input  logic [7:0]  control_base_addr,
  input  logic        dev_ready,
  output logic        ac_sel,
  output logic        toccata_sel,
  output logic        control_sel,
  output logic        bus_ready,
  output logic        bus_error
);

  localparam logic [7:0] WAIT_TOC_C = 8'(WAIT_TOCCATA);
  localparam logic [7:0] WAIT_CTL_C = 8'(WAIT_CONTROL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_WAIT   = 3'd2,
    S_ACK    = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       ac_sel_q, ac_sel_d;
  logic       toc_sel_q, toc_sel_d;
  logic       ctl_sel_q, ctl_sel_d;
  logic       rdy_q, rdy_d;
  logic       hit_ac_s, hit_toc_s, hit_ctl_s;
  logic [7:0] cnt_dec_s;
  logic       timeout_s;
  logic       unused_ok_s;

  assign unused_ok_s = ^{cpu_addr[15:1], board_configured[3:0], board_shutup[3:0], 8'(TIMEOUT_TICKS)};

  // Priority match on the latched address; board flags are only looked at here, in DECODE.
  always_comb begin
    hit_ac_s  = (addr_q == 8'hE8) && !autoconfig_done;
    hit_toc_s = !hit_ac_s && (addr_q == toccata_base_addr) && board_configured[4] && !board_shutup[4];
    hit_ctl_s = !hit_ac_s && !hit_toc_s && (addr_q == control_base_addr)
                && board_configured[5] && !board_shutup[5];
    cnt_dec_s = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
  end

`ifdef ZORRO_TIMEOUT_EN
  localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT_TICKS - 1);
  logic [7:0] to_q, to_d;
  logic       err_q, err_d;

  assign timeout_s = (to_q == TO_LAST_C);

  // Timeout counter: cleared when WAIT is entered, counts every tick spent in WAIT.
  always_comb begin
    if (state_q == S_DECODE && state_d == S_WAIT) begin
      to_d = 8'd0;
    end else if (state_q == S_WAIT) begin
      to_d = to_q + 8'd1;
    end else begin
      to_d = to_q;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register; a fresh cpu_as rise is required after reset (armed_q).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= 8'd0;
      cnt_q     <= 8'd0;
      armed_q   <= 1'b0;
      ac_sel_q  <= 1'b0;
      toc_sel_q <= 1'b0;
      ctl_sel_q <= 1'b0;
      rdy_q     <= 1'b0;
`ifdef ZORRO_TIMEOUT_EN
      to_q      <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else if (clk7_en) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      ac_sel_q  <= ac_sel_d;
      toc_sel_q <= toc_sel_d;
      ctl_sel_q <= ctl_sel_d;
      rdy_q     <= rdy_d;
`ifdef ZORRO_TIMEOUT_EN
      to_q      <= to_d;
      err_q     <= err_d;
`endif
    end
  end

  // Next-state logic; a dropped cpu_as aborts any active cycle straight back to IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    armed_d = armed_q | ~cpu_as;
    case (state_q)
      S_IDLE: begin
        if (cpu_as && armed_q) begin
          state_d = S_DECODE;
          addr_d  = cpu_addr[23:16];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (!cpu_as) begin
          state_d = S_IDLE;
        end else if (hit_ac_s) begin
          state_d = S_ACK;
        end else if (hit_toc_s) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_TOC_C;
        end else if (hit_ctl_s) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_CTL_C;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_dec_s;
        if (!cpu_as) begin
          state_d = S_IDLE;
        end else if (cnt_dec_s == 8'd0 && dev_ready) begin
          state_d = S_ACK;
        end else if (timeout_s) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACK: begin
        if (!cpu_as) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!cpu_as) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next values: selects latch on leaving DECODE, ready on entering ACK.
  always_comb begin
    ac_sel_d  = ac_sel_q;
    toc_sel_d = toc_sel_q;
    ctl_sel_d = ctl_sel_q;
    rdy_d     = rdy_q;
`ifdef ZORRO_TIMEOUT_EN
    err_d     = err_q;
`endif
    if (state_d == S_IDLE) begin
      ac_sel_d  = 1'b0;
      toc_sel_d = 1'b0;
      ctl_sel_d = 1'b0;
      rdy_d     = 1'b0;
`ifdef ZORRO_TIMEOUT_EN
      err_d     = 1'b0;
`endif
    end else begin
      if (state_q == S_DECODE) begin
        ac_sel_d  = hit_ac_s;
        toc_sel_d = hit_toc_s;
        ctl_sel_d = hit_ctl_s;
      end else begin
        ac_sel_d  = ac_sel_q;
      end
      if (state_d == S_ACK) begin
        rdy_d = 1'b1;
      end else begin
        rdy_d = rdy_q;
      end
`ifdef ZORRO_TIMEOUT_EN
      if (state_q == S_WAIT && state_d == S_HOLD) begin
        err_d = 1'b1;
        rdy_d = 1'b0;
      end else begin
        err_d = err_q;
      end
`endif
    end
  end

  assign ac_sel      = ac_sel_q;
  assign toccata_sel = toc_sel_q;
  assign control_sel = ctl_sel_q;
  assign bus_ready   = rdy_q;
`ifdef ZORRO_TIMEOUT_EN
  assign bus_error   = err_q;
`else
  assign bus_error   = 1'b0;
`endif

endmodule

// File: tb/tb_minimig_zorro_decode.sv
// Scoreboard bench for minimig_zorro_decode: per-tick expected outputs {ac,toc,ctl,rdy,err} are queued and compared.
module tb_minimig_zorro_decode;

`ifdef ZORRO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7_en;
  logic [23:1] cpu_addr;
  logic        cpu_as;
  logic        autoconfig_done;
  logic [5:0]  board_configured;
  logic [5:0]  board_shutup;
  logic [7:0]  toccata_base_addr;
  logic [7:0]  control_base_addr;
  logic        dev_ready;
  logic        ac_sel, toccata_sel, control_sel, bus_ready, bus_error;
  logic [4:0]  outs_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];
  string      tag_q[$];

  minimig_zorro_decode dut (
    .clk               (clk),
    .reset             (reset),
    .clk7_en           (clk7_en),
    .cpu_addr          (cpu_addr),
    .cpu_as            (cpu_as),
    .autoconfig_done   (autoconfig_done),
    .board_configured  (board_configured),
    .board_shutup      (board_shutup),
    .toccata_base_addr (toccata_base_addr),
    .control_base_addr (control_base_addr),
    .dev_ready         (dev_ready),
    .ac_sel            (ac_sel),
    .toccata_sel       (toccata_sel),
    .control_sel       (control_sel),
    .bus_ready         (bus_ready),
    .bus_error         (bus_error)
  );

  always #5 clk = ~clk;

  assign outs_s = {ac_sel, toccata_sel, control_sel, bus_ready, bus_error};

  task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (ac,toc,ctl,rdy,err)", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      check_eq(tag_q.pop_front(), outs_s, exp_q.pop_front());
    end
  endtask

  // One enabled edge followed by one disabled edge; outputs sampled on the falling edge.
  task automatic tick();
    clk7_en = 1'b1;
    @(posedge clk);
    #1 clk7_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic as, input logic [4:0] exp, input string tag);
    cpu_as = as;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    compare_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    clk7_en           = 1'b0;
    cpu_as            = 1'b0;
    cpu_addr          = 23'd0;
    autoconfig_done   = 1'b0;
    board_configured  = 6'b110000;
    board_shutup      = 6'b000000;
    toccata_base_addr = 8'hE9;
    control_base_addr = 8'hEA;
    dev_ready         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("reset", outs_s, 5'b00000);
    reset = 1'b0;
    step(1'b0, 5'b00000, "idle");

    // Autoconfig window: zero wait states.
    cpu_addr = {8'hE8, 15'h0123};
    step(1'b1, 5'b00000, "ac_decode");
    step(1'b1, 5'b10010, "ac_ack");
    step(1'b1, 5'b10010, "ac_hold");
    step(1'b1, 5'b10010, "ac_hold2");
    step(1'b0, 5'b00000, "ac_release");
    step(1'b0, 5'b00000, "ac_idle");

    // Toccata, two wait ticks; base change mid-cycle must not matter.
    cpu_addr = {8'hE9, 15'h0040};
    step(1'b1, 5'b00000, "toc_decode");
    step(1'b1, 5'b01000, "toc_wait1");
    toccata_base_addr = 8'h00;
    step(1'b1, 5'b01000, "toc_wait2");
    step(1'b1, 5'b01010, "toc_ack");
    step(1'b1, 5'b01010, "toc_hold");
    step(1'b0, 5'b00000, "toc_release");
    toccata_base_addr = 8'hE9;

    // Toccata shut up: cycle ignored.
    board_shutup = 6'b010000;
    step(1'b1, 5'b00000, "shut_decode");
    step(1'b1, 5'b00000, "shut_hold");
    step(1'b1, 5'b00000, "shut_hold2");
    step(1'b0, 5'b00000, "shut_release");
    board_shutup = 6'b000000;

    // Autoconfig done: E8 no longer matches.
    autoconfig_done = 1'b1;
    cpu_addr = {8'hE8, 15'h0000};
    step(1'b1, 5'b00000, "acdone_decode");
    step(1'b1, 5'b00000, "acdone_hold");
    step(1'b0, 5'b00000, "acdone_release");

    // Control board with dev_ready low, then ready (or timeout).
    cpu_addr  = {8'hEA, 15'h0002};
    dev_ready = 1'b0;
    step(1'b1, 5'b00000, "ctl_decode");
    step(1'b1, 5'b00100, "ctl_wait_entry");
    for (int i = 3; i <= 70; i++) begin
      step(1'b1, (TO_EN && i >= 66) ? 5'b00101 : 5'b00100, $sformatf("ctl_wait%0d", i));
    end
    dev_ready = 1'b1;
    step(1'b1, TO_EN ? 5'b00101 : 5'b00110, "ctl_ready");
    step(1'b1, TO_EN ? 5'b00101 : 5'b00110, "ctl_hold");
    step(1'b0, 5'b00000, "ctl_release");

    // Abort in WAIT.
    cpu_addr = {8'hE9, 15'h0000};
    step(1'b1, 5'b00000, "abort_decode");
    step(1'b1, 5'b01000, "abort_wait");
    step(1'b0, 5'b00000, "abort_idle");
    step(1'b0, 5'b00000, "abort_idle2");

    // Reset in ACK with clk7_en low, then re-arm only on a fresh cpu_as rise.
    autoconfig_done = 1'b0;
    cpu_addr = {8'hE8, 15'h0000};
    step(1'b1, 5'b00000, "rst_decode");
    step(1'b1, 5'b10010, "rst_ack");
    reset   = 1'b1;
    clk7_en = 1'b0;
    exp_q.push_back(5'b00000);
    tag_q.push_back("rst_in_ack");
    @(posedge clk);
    @(negedge clk);
    compare_out();
    reset = 1'b0;
    step(1'b1, 5'b00000, "norearm1");
    step(1'b1, 5'b00000, "norearm2");
    step(1'b0, 5'b00000, "rearm_low");
    step(1'b1, 5'b00000, "rearm_decode");
    step(1'b1, 5'b10010, "rearm_ack");
    step(1'b0, 5'b00000, "rearm_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
